// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if : stall-request / exception bus between the core stages and
//                the pipeline sequencer.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             excp_valid;
  logic [31:0]      excp_target;
  logic             cnt_clr;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_target, cnt_clr,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_target, cnt_clr,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl : 5-stage pipeline sequencer - stall merge, exception flush /
//             redirect, stall watchdog and stall-cycle counter.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  wire logic  clk,
  input  wire logic  rst,
  pipe_ctrl_if.slave bus
);

  localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SET_W-1:0]   settle_cnt;
  logic [RUN_W-1:0]   run_len;
  logic               flush_q;
  logic [31:0]        new_pc_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [5:0]         stall_c;

  // A stall freezes the requester and everything upstream; later stages drain.
  always_comb begin
    stall_c = 6'b000000;
    if (!rst && state != S_FLUSH) begin
      if (bus.stallreq_mem)     stall_c = 6'b011111;
      else if (bus.stallreq_ex) stall_c = 6'b001111;
      else if (bus.stallreq_id) stall_c = 6'b000111;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:    if (bus.excp_valid) state_nxt = S_FLUSH;
      S_FLUSH:  state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) state_nxt = S_RUN;
      default:  state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      flush_q    <= 1'b0;
      new_pc_q   <= 32'h0;
      settle_cnt <= '0;
    end else begin
      state   <= state_nxt;
      flush_q <= (state_nxt == S_FLUSH);
      if (state == S_RUN && bus.excp_valid)
        new_pc_q <= bus.excp_target;
      if (state == S_FLUSH)
        settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
      else if (state == S_SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Flag is raised on the same edge run_len reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_len   <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (stall_c[0]) begin
        if (run_len != RUN_W'(STALL_TIMEOUT))
          run_len <= run_len + 1'b1;
        if (run_len >= RUN_W'(STALL_TIMEOUT - 1))
          timeout_q <= 1'b1;
      end else begin
        run_len <= '0;
      end

      if (bus.cnt_clr)
        cnt_q <= '0;
      else if (stall_c[0] && !(&cnt_q))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_q;
  assign bus.new_pc        = new_pc_q;
  assign bus.stall_timeout = timeout_q;
  assign bus.stall_cycles  = cnt_q;

endmodule

`default_nettype wire
